// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - restoring divider sequencer driving an external adder/subtractor
module div_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV0,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_SEL,
    input  logic [WIDTH-1:0] ALU_SUM,
    input  logic             ALU_COUT
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Partial remainder for this iteration: R shifted left with the next
    // dividend bit, keeping the bit that falls off the top (rt). When rt is
    // set the true partial remainder is >= 2^WIDTH > D, so the subtract is
    // always taken and the wrapped ALU result is the correct new remainder.
    logic             rt;
    logic [WIDTH-1:0] ps;
    logic             ok;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_sel;

    // Shift/compare datapath feeding the external subtractor.
    always_comb begin
        {rt, ps} = {r_q, q_q[WIDTH-1]};
        ok       = rt | ALU_COUT;
    end

    // Next-state, register updates and ALU drive.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    d_d    = DIVISOR;
                    q_d    = DIVIDEND;
                    r_d    = '0;
                    div0_d = 1'b0;
                    busy_d = 1'b1;
                    if (DIVISOR != '0) begin
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = ST_ITER;
                    end else begin
                        state_d = ST_ZERO;
                    end
                end
            end

            ST_ITER: begin
                alu_a   = ps;
                alu_b   = d_q;
                alu_sel = 1'b1;
                r_d     = ok ? ALU_SUM : ps;
                q_d     = {q_q[WIDTH-2:0], ok};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_ZERO: begin
                // Dividend was parked in the quotient register at START.
                quot_d  = '1;
                rem_d   = q_q;
                div0_d  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign DIV0    = div0_q;
    assign QUOT    = quot_q;
    assign REM     = rem_q;
    assign ALU_A   = alu_a;
    assign ALU_B   = alu_b;
    assign ALU_SEL = alu_sel;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl
module tb_div_seq_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d0;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div0;
    logic [W-1:0] quot, rem, alu_a, alu_b, alu_sum;
    logic         alu_sel, alu_cout;
    logic [W:0]   alu_res;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .DIVIDEND(dividend),
        .DIVISOR (divisor),
        .BUSY    (busy),
        .DONE    (done),
        .DIV0    (div0),
        .QUOT    (quot),
        .REM     (rem),
        .ALU_A   (alu_a),
        .ALU_B   (alu_b),
        .ALU_SEL (alu_sel),
        .ALU_SUM (alu_sum),
        .ALU_COUT(alu_cout)
    );

    // Shared 4-bit adder/subtractor: subtract as A + ~B + 1, carry = no borrow.
    always_comb begin
        if (alu_sel) alu_res = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        else         alu_res = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_sum  = alu_res[W-1:0];
    assign alu_cout = alu_res[W];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE pops one expected result and checks it.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("quot", {28'd0, quot}, {28'd0, mon_e.q});
                chk("rem", {28'd0, rem}, {28'd0, mon_e.r});
                chk("div0", {31'd0, div0}, {31'd0, mon_e.d0});
                chk("done_cycle", cyc, mon_e.cyc);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic d0, input int c);
        exp_t e;
        e.q = q; e.r = r; e.d0 = d0; e.cyc = c;
        sb.push_back(e);
    endtask

    // One-cycle START pulse; expected DONE cycle derived from acceptance edge.
    task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic d0);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        push_exp(q, r, d0, cyc + 1 + ((dv == 0) ? 1 : W));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {12'd0, busy, done, div0, quot, rem, alu_a, alu_b, alu_sel};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_held_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // 13/3 with BUSY / ALU_SEL window check
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        push_exp(4'd4, 4'd1, 1'b0, cyc + 1 + W);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            chk("busy_window", {31'd0, busy}, (i <= 4) ? 32'd1 : 32'd0);
            chk("alu_sel_window", {31'd0, alu_sel}, (i <= 4) ? 32'd1 : 32'd0);
            chk("alu_b_window", {28'd0, alu_b}, (i <= 4) ? 32'd3 : 32'd0);
        end
        drain();

        // Directed vectors
        start_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);  drain();
        start_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);  drain();
        start_op(4'd2, 4'd5, 4'd0, 4'd2, 1'b0);    drain();
        start_op(4'd14, 4'd9, 4'd1, 4'd5, 1'b0);   drain();

        // Divide by zero, then flag hold / clear behaviour
        start_op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);   drain();
        chk("div0_hold", {31'd0, div0}, 32'd1);
        chk("quot_hold_after_div0", {28'd0, quot}, 32'd15);
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd3;
        start    = 1'b1;
        push_exp(4'd2, 4'd0, 1'b0, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
        chk("div0_clear_on_start", {31'd0, div0}, 32'd0);
        chk("quot_hold_until_done", {28'd0, quot}, 32'd15);
        chk("rem_hold_until_done", {28'd0, rem}, 32'd7);
        drain();

        // START pulses while busy are ignored
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        push_exp(4'd4, 4'd1, 1'b0, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd8;
        divisor  = 4'd0;
        @(negedge clk);
        start = 1'b0;
        drain();

        // START held high: accepted again in each DONE cycle
        begin
            int c0;
            @(negedge clk);
            c0       = cyc;
            dividend = 4'd9;
            divisor  = 4'd2;
            start    = 1'b1;
            push_exp(4'd4, 4'd1, 1'b0, c0 + 5);
            push_exp(4'd4, 4'd1, 1'b0, c0 + 10);
            push_exp(4'd4, 4'd1, 1'b0, c0 + 15);
            repeat (14) @(negedge clk);
            start = 1'b0;
            drain();
        end

        // Asynchronous reset mid-operation aborts without DONE
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", {31'd0, done}, 32'd0);
        start_op(4'd10, 4'd4, 4'd2, 4'd2, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
